// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow error flags and synchronous flush.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              write,
  input  logic [DATA_W-1:0] din,
  input  logic              read,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              flush,
  input  logic              clr_err,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  // Wrap bit makes the subtraction exact for count in 0..DEPTH
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A read on a full FIFO frees the slot the write lands in
  assign rd_acc = read && !empty && !flush;
  assign wr_acc = write && !flush && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[ADDR_W-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_acc;
      if (rd_acc) begin
        dout   <= mem[rd_ptr[ADDR_W-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Set has priority over clr_err so no rejection is lost
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write && !wr_acc && !flush) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (read && !rd_acc && !flush) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (default parameters).
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_sync_fifo_param;

  logic       clk;
  logic       rstn;
  logic       write;
  logic [7:0] din;
  logic       read;
  logic [7:0] dout;
  logic       dout_valid;
  logic       flush;
  logic       clr_err;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int n_cmp = 0;
  int n_bad = 0;

  sync_fifo_param dut (
    .clk(clk), .rstn(rstn),
    .write(write), .din(din),
    .read(read), .dout(dout),
    .dout_valid(dout_valid),
    .flush(flush), .clr_err(clr_err),
    .empty(empty), .full(full),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; write = 1'b0; read = 1'b0;
    din = '0; flush = 1'b0; clr_err = 1'b0;
    #2;
    n_cmp++;
    if ({count, empty, full, almost_empty, almost_full,
         overflow, underflow, dout, dout_valid}
        !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: count=%0d e=%b f=%b ae=%b af=%b ov=%b uf=%b dout=%h dv=%b, want 0 1 0 1 0 0 0 00 0",
               count, empty, full, almost_empty, almost_full,
               overflow, underflow, dout, dout_valid);
    end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      write = 1'b1; din = 8'(8'h10 + i);
      tick();
      n_cmp++;
      if ({count, almost_full, full} !==
          {5'(i + 1), (i + 1 >= 12), (i + 1 == 16)}) begin
        n_bad++;
        $display("FAIL fill[%0d]: count=%0d af=%b f=%b, want %0d %b %b",
                 i, count, almost_full, full, i + 1,
                 (i + 1 >= 12), (i + 1 == 16));
      end
    end
    din = 8'hEE;
    tick();
    write = 1'b0;
    n_cmp++;
    if ({overflow, count, full} !== {1'b1, 5'd16, 1'b1}) begin
      n_bad++;
      $display("FAIL overflow: ov=%b count=%0d f=%b, want 1 16 1",
               overflow, count, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      read = 1'b1;
      tick();
      n_cmp++;
      if ({dout, dout_valid, count, almost_empty, empty} !==
          {8'(8'h10 + i), 1'b1, 5'(15 - i), (15 - i <= 4), (i == 15)}) begin
        n_bad++;
        $display("FAIL drain[%0d]: dout=%h dv=%b count=%0d ae=%b e=%b, want %h 1 %0d %b %b",
                 i, dout, dout_valid, count, almost_empty, empty,
                 8'(8'h10 + i), 15 - i, (15 - i <= 4), (i == 15));
      end
    end
    tick();
    read = 1'b0;
    n_cmp++;
    if ({underflow, dout, dout_valid, count} !==
        {1'b1, 8'h1F, 1'b0, 5'd0}) begin
      n_bad++;
      $display("FAIL underflow: uf=%b dout=%h dv=%b count=%0d, want 1 1f 0 0",
               underflow, dout, dout_valid, count);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++;
    if ({overflow, underflow} !== 2'b00) begin
      n_bad++;
      $display("FAIL clr_err: ov=%b uf=%b, want 0 0",
               overflow, underflow);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) begin
      write = 1'b1; din = 8'(8'h20 + i);
      tick();
    end
    read = 1'b1; din = 8'hAA;
    tick();
    write = 1'b0;
    n_cmp++;
    if ({count, overflow, dout, dout_valid} !==
        {5'd16, 1'b0, 8'h20, 1'b1}) begin
      n_bad++;
      $display("FAIL full_rw: count=%0d ov=%b dout=%h dv=%b, want 16 0 20 1",
               count, overflow, dout, dout_valid);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      n_cmp++;
      if (dout !== 8'(8'h21 + i)) begin
        n_bad++;
        $display("FAIL full_rw_rd[%0d]: dout=%h, want %h",
                 i, dout, 8'(8'h21 + i));
      end
    end
    tick();
    read = 1'b0;
    n_cmp++;
    if ({dout, dout_valid, count} !== {8'hAA, 1'b1, 5'd0}) begin
      n_bad++;
      $display("FAIL full_rw_last: dout=%h dv=%b count=%0d, want aa 1 0",
               dout, dout_valid, count);
    end
  endtask

  task automatic test_empty_rw();
    write = 1'b1; read = 1'b1; din = 8'h55;
    tick();
    write = 1'b0;
    n_cmp++;
    if ({count, underflow, dout_valid} !== {5'd1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL empty_rw: count=%0d uf=%b dv=%b, want 1 1 0",
               count, underflow, dout_valid);
    end
    tick();
    read = 1'b0;
    n_cmp++;
    if ({dout, dout_valid, count} !== {8'h55, 1'b1, 5'd0}) begin
      n_bad++;
      $display("FAIL empty_rw_rd: dout=%h dv=%b count=%0d, want 55 1 0",
               dout, dout_valid, count);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 40; k++) begin
      write = 1'b1; din = 8'(8'h60 + k);
      tick();
      write = 1'b0;
      n_cmp++;
      if (count !== 5'd1) begin
        n_bad++;
        $display("FAIL wrap_wr[%0d]: count=%0d, want 1", k, count);
      end
      read = 1'b1;
      tick();
      read = 1'b0;
      n_cmp++;
      if ({dout, dout_valid, count} !== {8'(8'h60 + k), 1'b1, 5'd0}) begin
        n_bad++;
        $display("FAIL wrap_rd[%0d]: dout=%h dv=%b count=%0d, want %h 1 0",
                 k, dout, dout_valid, count, 8'(8'h60 + k));
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) begin
      write = 1'b1; din = 8'(8'h30 + i);
      tick();
    end
    n_cmp++;
    if (count !== 5'd7) begin
      n_bad++;
      $display("FAIL flush_pre: count=%0d, want 7", count);
    end
    flush = 1'b1; din = 8'hCC;
    tick();
    flush = 1'b0; write = 1'b0;
    n_cmp++;
    if ({count, empty, overflow, dout, dout_valid} !==
        {5'd0, 1'b1, 1'b0, 8'h87, 1'b0}) begin
      n_bad++;
      $display("FAIL flush: count=%0d e=%b ov=%b dout=%h dv=%b, want 0 1 0 87 0",
               count, empty, overflow, dout, dout_valid);
    end
  endtask

  task automatic test_clr_err();
    for (int i = 0; i < 16; i++) begin
      write = 1'b1; din = 8'(8'h40 + i);
      tick();
    end
    clr_err = 1'b1;
    tick();
    write = 1'b0;
    n_cmp++;
    if ({overflow, count} !== {1'b1, 5'd16}) begin
      n_bad++;
      $display("FAIL clr_set_wins: ov=%b count=%0d, want 1 16",
               overflow, count);
    end
    tick();
    clr_err = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_alone: ov=%b, want 0", overflow);
    end
  endtask

  task automatic test_reset_mid();
    read = 1'b1;
    tick();
    read = 1'b0;
    n_cmp++;
    if ({dout, dout_valid, count} !== {8'h40, 1'b1, 5'd15}) begin
      n_bad++;
      $display("FAIL mid_pre: dout=%h dv=%b count=%0d, want 40 1 15",
               dout, dout_valid, count);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({count, empty, full, almost_empty, almost_full,
         overflow, underflow, dout, dout_valid}
        !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: count=%0d e=%b f=%b ae=%b af=%b ov=%b uf=%b dout=%h dv=%b, want 0 1 0 1 0 0 0 00 0",
               count, empty, full, almost_empty, almost_full,
               overflow, underflow, dout, dout_valid);
    end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_flush();
    test_clr_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
